mux_8_1_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 multiplexed 32-bit datapath among eight requesters.
- Its registered outputs `sel` and `enb` drive the select and enable inputs of the Mux_8_1 instance directly. `gnt` returns a one-hot grant to the requesters.
- Per-grant burst limit prevents any requester from monopolising the path. Sits in front of shared-bus sources (e.g. operand/result buses between units).

---
 rtl/mux_8_1_arbiter.sv | 102 ++++++++++
 tb/tb_mux_8_1_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mux_8_1_arbiter.sv
// Round-robin arbiter granting one of eight requesters the shared 8:1 32-bit mux path.
// Latency: one cycle from req to gnt/sel/enb; all outputs registered.
// Backpressure: a holder keeps the path at most MAX_BURST cycles, then re-arbitration is forced.
module mux_8_1_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [0:7]       req_i,
  output logic [0:7]       gnt_o,
  output logic [0:2]       sel_o,
  output logic             enb_o,
  output logic [0:CNT_W-1] burst_cnt_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [0:7]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             enb_q, enb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       win;
  logic             found;
  logic [2:0]       idx;
  logic             hold;

  // Scan for the next requester starting just after the last winner; the last
  // winner itself is visited last, so it is re-granted only when alone.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!found && req_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // The current holder keeps the path while it still requests and has burst budget left.
  always_comb begin
    hold = (state_q == GRANT) && req_i[last_q] && (cnt_q < CNT_W'(MAX_BURST));
  end

  // Next-state and output-register logic: hold, hand over back-to-back, or go idle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    enb_d   = enb_q;
    cnt_d   = cnt_q;
    if (hold) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (found) begin
      state_d    = GRANT;
      last_d     = win;
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      sel_d      = win;
      enb_d      = 1'b1;
      cnt_d      = CNT_W'(1);
    end else begin
      // sel is left as-is; it is meaningless while enb is low.
      state_d = IDLE;
      gnt_d   = '0;
      enb_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  // State and output registers; reset points the pointer at 7 so requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      gnt_q   <= '0;
      sel_q   <= '0;
      enb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      enb_q   <= enb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign enb_o       = enb_q;
  assign burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_mux_8_1_arbiter.sv
// Directed-vector and randomized bench for the round-robin mux arbiter.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that point.
// A behavioural 8:1 mux driven by sel/enb shows the datapath each holder gets.
module tb_mux_8_1_arbiter;

  localparam int MAXB = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:7]    req;
  logic [0:7]    gnt;
  logic [0:2]    sel;
  logic          enb;
  logic [0:CW-1] bcnt;

  mux_8_1_arbiter #(.MAX_BURST(MAXB), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt),
    .sel_o       (sel),
    .enb_o       (enb),
    .burst_cnt_o (bcnt)
  );

  always #5 clk = ~clk;

  // Shared-bus sources and the mux they feed.
  logic [31:0] a [8];
  logic [31:0] y;
  always_comb y = enb ? a[sel] : 32'h0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    int         sel;
    logic       enb;
    int         cnt;
  } vec_t;

  vec_t vt [22];

  logic [0:7] req_prev;
  int         wait_c [8];
  int         holder;
  int         max_wait;

  initial begin
    for (int i = 0; i < 8; i++) a[i] = 32'h010101 * (i + 1);
    rst = 1'b1;
    req = '0;

    //          rst   req    gnt    sel enb cnt
    vt[0]  = '{1'b1, 8'h00, 8'h00, 0, 1'b0, 0};
    vt[1]  = '{1'b0, 8'h00, 8'h00, 0, 1'b0, 0};
    vt[2]  = '{1'b0, 8'h00, 8'h00, 0, 1'b0, 0};
    vt[3]  = '{1'b0, 8'h00, 8'h00, 0, 1'b0, 0};
    vt[4]  = '{1'b0, 8'h00, 8'h00, 0, 1'b0, 0};
    vt[5]  = '{1'b0, 8'h00, 8'h00, 0, 1'b0, 0};
    // requester 0 for two cycles, then drop
    vt[6]  = '{1'b0, 8'h80, 8'h80, 0, 1'b1, 1};
    vt[7]  = '{1'b0, 8'h80, 8'h80, 0, 1'b1, 2};
    vt[8]  = '{1'b0, 8'h00, 8'h00, 0, 1'b0, 0};
    // requester 5 alone: burst limit re-grants it with no bubble
    vt[9]  = '{1'b0, 8'h04, 8'h04, 5, 1'b1, 1};
    vt[10] = '{1'b0, 8'h04, 8'h04, 5, 1'b1, 2};
    vt[11] = '{1'b0, 8'h04, 8'h04, 5, 1'b1, 3};
    vt[12] = '{1'b0, 8'h04, 8'h04, 5, 1'b1, 4};
    vt[13] = '{1'b0, 8'h04, 8'h04, 5, 1'b1, 1};
    vt[14] = '{1'b0, 8'h04, 8'h04, 5, 1'b1, 2};
    // 5 drops, 1 and 6 request: 6 wins, then drops and 1 follows via wrap
    vt[15] = '{1'b0, 8'h42, 8'h02, 6, 1'b1, 1};
    vt[16] = '{1'b0, 8'h42, 8'h02, 6, 1'b1, 2};
    vt[17] = '{1'b0, 8'h40, 8'h40, 1, 1'b1, 1};
    // idle keeps the last sel
    vt[18] = '{1'b0, 8'h00, 8'h00, 1, 1'b0, 0};
    // all request from pointer 1 -> requester 2; then reset mid-grant
    vt[19] = '{1'b0, 8'hFF, 8'h20, 2, 1'b1, 1};
    vt[20] = '{1'b1, 8'hFF, 8'h00, 0, 1'b0, 0};
    vt[21] = '{1'b0, 8'h00, 8'h00, 0, 1'b0, 0};

    for (int v = 0; v < 22; v++) begin
      rst = vt[v].rst;
      req = vt[v].req;
      tick();
      chk($sformatf("vec%0d gnt", v), 32'(gnt),  32'(vt[v].gnt));
      chk($sformatf("vec%0d sel", v), 32'(sel),  32'(vt[v].sel));
      chk($sformatf("vec%0d enb", v), 32'(enb),  32'(vt[v].enb));
      chk($sformatf("vec%0d cnt", v), 32'(bcnt), 32'(vt[v].cnt));
    end

    // All eight requesting from reset: 0..7 in order, four cycles each, mux data follows.
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("all8 c%0d gnt", k), 32'(gnt),  32'(8'h80 >> ((k / 4) % 8)));
      chk($sformatf("all8 c%0d sel", k), 32'(sel),  32'((k / 4) % 8));
      chk($sformatf("all8 c%0d enb", k), 32'(enb),  32'd1);
      chk($sformatf("all8 c%0d cnt", k), 32'(bcnt), 32'((k % 4) + 1));
      chk($sformatf("all8 c%0d y", k),   y,         32'h010101 * (((k / 4) % 8) + 1));
    end

    // Random sticky requests with invariant, legality and starvation checks.
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) wait_c[i] = 0;
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      req_prev = req;
      tick();
      chk("rnd onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("rnd enb==|gnt", 32'(enb), 32'(|gnt));
      if (enb) begin
        chk("rnd gnt/sel", 32'(gnt), 32'(8'h80 >> sel));
        chk("rnd gnt had req", 32'(|(gnt & req_prev)), 32'd1);
        chk("rnd cnt range", 32'((bcnt >= 1) && (bcnt <= MAXB)), 32'd1);
      end else begin
        chk("rnd idle cnt", 32'(bcnt), 32'd0);
        chk("rnd idle no req", 32'(req_prev), 32'd0);
      end
      holder = -1;
      for (int i = 0; i < 8; i++) if (gnt[i]) holder = i;
      for (int i = 0; i < 8; i++) begin
        if (!req_prev[i] || holder == i) wait_c[i] = 0;
        else wait_c[i]++;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
    end
    chk("rnd starvation bound", 32'(max_wait <= 7 * MAXB), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
